// File: rtl/gbe_arb_pkg.sv
// gbe_arb_pkg: shared state encoding, counter widths and lane-slice helper for the TX arbiter.
package gbe_arb_pkg;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
  localparam int TO_W = 16;
  localparam int BC_W = 14;
  function automatic logic [31:0] lane(input logic [255:0] v, input int w, input int i);
    return 32'(v >> (w * i)) & 32'((33'd1 << w) - 33'd1);
  endfunction
endpackage

// File: rtl/gbe_rr_pick.sv
// gbe_rr_pick: combinational round-robin picker, first valid at or after ptr (cyclic).
module gbe_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          found
);
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % N]) win = N'(1) << ((int'(ptr) + k) % N);
  end
  assign found = |valid;
endmodule

// File: rtl/gbe_app_tx_arb.sv
// gbe_app_tx_arb: packet-granular round-robin arbiter onto the gbe_udp app TX port.
// Optional GBE_ARB_PKT_LIMIT_EN forces eof on the MAX_PKT_BYTES-th byte of a packet.
module gbe_app_tx_arb
  import gbe_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int MAX_PKT_BYTES = 8192
) (
  input  logic                  app_clk,
  input  logic                  app_rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [8*N_REQ-1:0]    req_data,
  input  logic [N_REQ-1:0]      req_dvld,
  input  logic [N_REQ-1:0]      req_eof,
  input  logic [32*N_REQ-1:0]   req_destip,
  input  logic [16*N_REQ-1:0]   req_destport,
  output logic [N_REQ-1:0]      req_grant,
  output logic                  req_afull,
  output logic [7:0]            app_tx_data,
  output logic                  app_tx_dvld,
  output logic                  app_tx_eof,
  output logic [31:0]           app_tx_destip,
  output logic [15:0]           app_tx_destport,
  input  logic                  app_tx_afull,
  output logic                  arb_timeout_err,
  output logic                  arb_proto_err
);
  localparam int IW = $clog2(N_REQ);
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, gi, win_i;
  logic [N_REQ-1:0] win;
  logic [TO_W-1:0] idle_cnt;
  logic found, g_dvld, g_eof, lim, abort, go, done, emit;
  gbe_rr_pick #(.N(N_REQ)) u_pick (.valid(req_valid), .ptr(rr_ptr), .win(win), .found(found));
  always_comb begin
    win_i = '0;
    for (int k = 0; k < N_REQ; k++) if (win[k]) win_i = IW'(k);
  end
  assign g_dvld = req_dvld[gi];
  assign g_eof = req_eof[gi];
`ifdef GBE_ARB_PKT_LIMIT_EN
  logic [BC_W-1:0] bcnt;
  assign lim = bcnt == BC_W'(MAX_PKT_BYTES - 1);
  always_ff @(posedge app_clk)
    if (app_rst || go) bcnt <= '0;
    else if (state == STREAM && g_dvld) bcnt <= bcnt + 1'b1;
`else
  assign lim = 1'b0;
`endif
  assign abort = !g_dvld && TIMEOUT != 0 && idle_cnt == TO_W'(TIMEOUT - 1);
  always_ff @(posedge app_clk)
    if (app_rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = go ? STREAM : done ? IDLE : state;
  always_comb begin
    go = state == IDLE && found && !app_tx_afull;
    done = state == STREAM && (g_dvld ? g_eof || lim : abort);
    emit = state == STREAM && (g_dvld || abort);
  end
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      req_grant <= '0;
      req_afull <= 1'b0;
      app_tx_data <= '0;
      app_tx_dvld <= 1'b0;
      app_tx_eof <= 1'b0;
      app_tx_destip <= '0;
      app_tx_destport <= '0;
      arb_timeout_err <= 1'b0;
      arb_proto_err <= 1'b0;
      rr_ptr <= '0;
      gi <= '0;
      idle_cnt <= '0;
    end else begin
      req_afull <= app_tx_afull;
      arb_proto_err <= |(req_dvld & ~req_grant);
      arb_timeout_err <= state == STREAM && (g_dvld ? lim && !g_eof : abort);
      app_tx_dvld <= emit;
      app_tx_eof <= done;
      idle_cnt <= (state == STREAM && !g_dvld) ? idle_cnt + 1'b1 : '0;
      if (emit) begin
        app_tx_data <= g_dvld ? 8'(lane(256'(req_data), 8, int'(gi))) : 8'h00;
        app_tx_destip <= lane(256'(req_destip), 32, int'(gi));
        app_tx_destport <= 16'(lane(256'(req_destport), 16, int'(gi)));
      end
      if (go) begin
        req_grant <= win;
        gi <= win_i;
      end else if (done) begin
        req_grant <= '0;
        rr_ptr <= (gi == IW'(N_REQ - 1)) ? '0 : gi + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gbe_app_tx_arb.sv
// tb_gbe_app_tx_arb: directed self-checking bench for gbe_app_tx_arb (TIMEOUT=16, MAX_PKT_BYTES=64).
module tb_gbe_app_tx_arb;
  logic app_clk = 0, app_rst = 1, app_tx_afull = 0;
  logic [3:0] req_valid = '0, req_dvld = '0, req_eof = '0, req_grant;
  logic [31:0] req_data = '0;
  logic [127:0] req_destip = '0;
  logic [63:0] req_destport = '0;
  logic req_afull, app_tx_dvld, app_tx_eof, arb_timeout_err, arb_proto_err;
  logic [7:0] app_tx_data;
  logic [31:0] app_tx_destip;
  logic [15:0] app_tx_destport;
  int n_cmp = 0, n_bad = 0;
  gbe_app_tx_arb #(.N_REQ(4), .TIMEOUT(16), .MAX_PKT_BYTES(64)) dut (
    .app_clk(app_clk), .app_rst(app_rst), .req_valid(req_valid), .req_data(req_data),
    .req_dvld(req_dvld), .req_eof(req_eof), .req_destip(req_destip), .req_destport(req_destport),
    .req_grant(req_grant), .req_afull(req_afull), .app_tx_data(app_tx_data), .app_tx_dvld(app_tx_dvld),
    .app_tx_eof(app_tx_eof), .app_tx_destip(app_tx_destip), .app_tx_destport(app_tx_destport),
    .app_tx_afull(app_tx_afull), .arb_timeout_err(arb_timeout_err), .arb_proto_err(arb_proto_err));
  always #5 app_clk = ~app_clk;
  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic pkt(input int r, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      req_dvld = '0;
      req_dvld[r] = 1'b1;
      req_data[8*r+:8] = base + 8'(i);
      req_eof = '0;
      req_eof[r] = i == n - 1;
      tick();
      chk("data", 64'(app_tx_data), 64'(base + 8'(i)));
      chk("dvld", 64'(app_tx_dvld), 64'd1);
      chk("eof", 64'(app_tx_eof), 64'(i == n - 1));
      chk("dip", 64'(app_tx_destip), 64'(req_destip[32*r+:32]));
      chk("dport", 64'(app_tx_destport), 64'(req_destport[16*r+:16]));
      chk("perr", 64'(arb_proto_err), 64'd0);
    end
    req_dvld = '0;
    req_eof = '0;
    chk("gap", 64'(req_grant), 64'd0);
  endtask
  initial begin
    req_destip = {32'h0A000004, 32'h0A000003, 32'h0A000002, 32'h0A000001};
    req_destport = {16'd5003, 16'd5002, 16'd5001, 16'd5000};
    tick();
    tick();
    chk("rst_grant", 64'(req_grant), 64'd0);
    chk("rst_dvld", 64'(app_tx_dvld), 64'd0);
    chk("rst_dip", 64'(app_tx_destip), 64'd0);
    chk("rst_terr", 64'(arb_timeout_err), 64'd0);
    app_rst = 0;
    req_valid = 4'b0101;
    tick();
    chk("rr0", 64'(req_grant), 64'b0001);
    pkt(0, 3, 8'h10);
    tick();
    chk("rr1", 64'(req_grant), 64'b0100);
    pkt(2, 3, 8'h20);
    tick();
    chk("rr2", 64'(req_grant), 64'b0001);
    pkt(0, 3, 8'h30);
    tick();
    chk("rr3", 64'(req_grant), 64'b0100);
    pkt(2, 3, 8'h40);
    req_valid = 4'b0011;
    tick();
    chk("ip_g0", 64'(req_grant), 64'b0001);
    pkt(0, 2, 8'h50);
    tick();
    chk("ip_g1", 64'(req_grant), 64'b0010);
    chk("ip_hold", 64'(app_tx_destip), 64'h0A000001);
    pkt(1, 2, 8'h60);
    chk("ip_sw", 64'(app_tx_destport), 64'd5001);
    req_valid = 4'b1111;
    app_tx_afull = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("afull_nogrant", 64'(req_grant), 64'd0);
    end
    chk("req_afull", 64'(req_afull), 64'd1);
    app_tx_afull = 0;
    tick();
    chk("afull_rel", 64'(req_grant), 64'b0100);
    req_valid = '0;
    pkt(2, 1, 8'h70);
    req_valid = 4'b0010;
    tick();
    chk("to_grant", 64'(req_grant), 64'b0010);
    req_valid = '0;
    req_dvld = 4'b0010;
    req_data[15:8] = 8'hA1;
    tick();
    chk("to_b0", 64'(app_tx_data), 64'hA1);
    req_dvld = 4'b1010;
    req_data[15:8] = 8'hA2;
    req_data[31:24] = 8'hEE;
    tick();
    chk("pe_data", 64'(app_tx_data), 64'hA2);
    chk("pe_dvld", 64'(app_tx_dvld), 64'd1);
    chk("pe_pulse", 64'(arb_proto_err), 64'd1);
    req_dvld = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_dvld", 64'(app_tx_dvld), 64'd0);
      chk("to_wait_err", 64'(arb_timeout_err), 64'd0);
    end
    chk("pe_once", 64'(arb_proto_err), 64'd0);
    req_valid = 4'b0110;
    tick();
    chk("to_dvld", 64'(app_tx_dvld), 64'd1);
    chk("to_eof", 64'(app_tx_eof), 64'd1);
    chk("to_data", 64'(app_tx_data), 64'd0);
    chk("to_dip", 64'(app_tx_destip), 64'h0A000002);
    chk("to_err", 64'(arb_timeout_err), 64'd1);
    chk("to_drop", 64'(req_grant), 64'd0);
    tick();
    chk("to_once", 64'(arb_timeout_err), 64'd0);
    chk("to_next", 64'(req_grant), 64'b0100);
    req_valid = '0;
    pkt(2, 1, 8'h80);
    req_dvld = 4'b0001;
    tick();
    chk("pe_idle", 64'(arb_proto_err), 64'd1);
    chk("pe_idle_dvld", 64'(app_tx_dvld), 64'd0);
    req_dvld = '0;
    req_valid = 4'b0001;
    tick();
    chk("big_grant", 64'(req_grant), 64'b0001);
    req_valid = '0;
    for (int i = 0; i < 100; i++) begin
      req_dvld = 4'b0001;
      req_data[7:0] = 8'(i);
      req_eof = {3'b0, i == 99};
      tick();
`ifdef GBE_ARB_PKT_LIMIT_EN
      if (i < 64) begin
        chk("lim_data", 64'(app_tx_data), 64'(i));
        chk("lim_eof", 64'(app_tx_eof), 64'(i == 63));
        chk("lim_err", 64'(arb_timeout_err), 64'(i == 63));
      end else begin
        chk("lim_dvld", 64'(app_tx_dvld), 64'd0);
        chk("lim_perr", 64'(arb_proto_err), 64'd1);
      end
`else
      chk("big_data", 64'(app_tx_data), 64'(i));
      chk("big_dvld", 64'(app_tx_dvld), 64'd1);
      chk("big_eof", 64'(app_tx_eof), 64'(i == 99));
      chk("big_err", 64'(arb_timeout_err), 64'd0);
`endif
    end
    req_dvld = '0;
    req_eof = '0;
    chk("big_end", 64'(req_grant), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
